vga_sync_gen: RTL and testbench

Upstream timing stage of the pipe-cleaning-robot display path. It divides the 50 MHz board clock into a 25 MHz pixel enable and generates the 640x480@60 Hz VGA raster. It drives the `pix_x`, `pix_y` and `video_on` inputs of the graphics renderer, and the `hsync`/`vsync` pins of the VGA connector. All outputs are registered and mutually consistent on every cycle.

---
 rtl/vga_sync_gen.sv | 76 +++++++
 tb/tb_vga_sync_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster generator driven from the 50 MHz board clock.
// A toggle divider gives the 25 MHz pixel enable; every output is registered from the next counter values.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock_50,
  input  logic       reset_n,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam logic [10:0] H_TOTAL  = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] V_TOTAL  = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 11'd1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 11'd1);
  localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       tick;
  logic [9:0] h_next;
  logic [9:0] v_next;

  assign pixel_tick = tick;

  // Next raster position: holds on the idle half of the divider, advances when tick is high
  always_comb begin
    h_next = pix_x;
    v_next = pix_y;
    if (tick) begin
      if (pix_x == H_LAST) begin
        h_next = '0;
        v_next = (pix_y == V_LAST) ? '0 : pix_y + 10'd1;
      end else begin
        h_next = pix_x + 10'd1;
      end
    end
  end

  // Decodes use the next values so syncs and video_on switch on the same edge as pix_x/pix_y
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      tick        <= 1'b0;
      pix_x       <= H_LAST;
      pix_y       <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick        <= ~tick;
      pix_x       <= h_next;
      pix_y       <= v_next;
      hsync       <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync       <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
      video_on    <= (h_next < H_VIS) && (v_next < V_VIS);
      frame_start <= tick && (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size raster for reset/line timing,
// a shrunken raster (15x9) for frame-level timing within a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic reset_n = 1'b0;

  logic [9:0] px, py, spx, spy;
  logic hs, vs, vo, pt, fs;
  logic shs, svs, svo, spt, sfs;
  logic [24:0] st, sst;

  int checks = 0;
  int passed = 0;

  localparam logic [24:0] RST  = {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [24:0] SRST = {10'd14, 10'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  vga_sync_gen dut (
    .clock_50(clk), .reset_n(reset_n), .pix_x(px), .pix_y(py), .video_on(vo),
    .hsync(hs), .vsync(vs), .pixel_tick(pt), .frame_start(fs)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clock_50(clk), .reset_n(reset_n), .pix_x(spx), .pix_y(spy), .video_on(svo),
    .hsync(shs), .vsync(svs), .pixel_tick(spt), .frame_start(sfs)
  );

  assign st  = {px, py, hs, vs, vo, pt, fs};
  assign sst = {spx, spy, shs, svs, svo, spt, sfs};

  always #10 if (clk_en) clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clk_en = 1'b1;
    reset_n = 1'b0;
    repeat (5) step();
    checks++; if (st !== RST) $display("FAIL rst_run: got %h want %h", st, RST); else passed++;
    checks++; if (sst !== SRST) $display("FAIL rst_run_small: got %h want %h", sst, SRST); else passed++;
    @(negedge clk); reset_n = 1'b1;
    repeat (7) step();
    @(negedge clk); clk_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checks++; if (st !== RST) $display("FAIL rst_noclk: got %h want %h", st, RST); else passed++;
    #100;
    checks++; if (st !== RST) $display("FAIL rst_noclk_hold: got %h want %h", st, RST); else passed++;
    clk_en = 1'b1;
    repeat (5) step();
    checks++; if (st !== RST) $display("FAIL rst_restart: got %h want %h", st, RST); else passed++;
  endtask

  task automatic test_release();
    @(negedge clk); reset_n = 1'b1;
    step();
    checks++; if (st !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL rel_edge1: got %h want %h", st, {10'd799, 10'd524, 5'b11010}); else passed++;
    step();
    checks++; if (st !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL rel_edge2: got %h want %h", st, {20'd0, 5'b11101}); else passed++;
    checks++; if (sst !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL rel_edge2_small: got %h want %h", sst, {20'd0, 5'b11101}); else passed++;
    step();
    checks++; if (st !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL rel_edge3: got %h want %h", st, {20'd0, 5'b11110}); else passed++;
    step();
    checks++; if (st !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL rel_edge4: got %h want %h", st, {10'd1, 10'd0, 5'b11100}); else passed++;
  endtask

  // Starts right after pix_x became 1 on line 0
  task automatic test_hline();
    int n = 0;
    int low = 0;
    logic [9:0] fall_x = 10'h3ff, rise_x = 10'h3ff, vo_x = 10'h3ff;
    logic prev_hs, prev_vo;
    while (n < 2000) begin
      prev_hs = hs;
      prev_vo = vo;
      step();
      n++;
      if (prev_hs && !hs) fall_x = px;
      if (!prev_hs && hs) rise_x = px;
      if (!hs) low++;
      if (prev_vo && !vo) vo_x = px;
      if (px == 10'd0) break;
    end
    checks++; if (fall_x !== 10'd656) $display("FAIL hs_fall_x: got %0d want 656", fall_x); else passed++;
    checks++; if (rise_x !== 10'd752) $display("FAIL hs_rise_x: got %0d want 752", rise_x); else passed++;
    checks++; if (low != 192) $display("FAIL hs_low_cycles: got %0d want 192", low); else passed++;
    checks++; if (vo_x !== 10'd640) $display("FAIL vo_fall_x: got %0d want 640", vo_x); else passed++;
    checks++; if (n != 1598) $display("FAIL line_cycles: got %0d want 1598", n); else passed++;
    checks++; if (py !== 10'd1) $display("FAIL line_wrap_y: got %0d want 1", py); else passed++;
  endtask

  task automatic test_frame();
    int n = 0;
    int vs_low = 0, vo_cnt = 0, bad_vs = 0;
    logic [9:0] prev_x = '0, prev_y = '0;
    while (!sfs && n < 600) begin step(); n++; end
    checks++; if (sfs !== 1'b1) $display("FAIL fs_found: got %b want 1", sfs); else passed++;
    for (int i = 0; i < 270; i++) begin
      if (!svs) vs_low++;
      if (svo) vo_cnt++;
      if (svs === ((spy == 10'd5) || (spy == 10'd6))) bad_vs++;
      prev_x = spx;
      prev_y = spy;
      step();
    end
    checks++; if (vs_low != 60) $display("FAIL vs_low_cycles: got %0d want 60", vs_low); else passed++;
    checks++; if (vo_cnt != 64) $display("FAIL vo_cycles: got %0d want 64", vo_cnt); else passed++;
    checks++; if (bad_vs != 0) $display("FAIL vs_rows: got %0d bad cycles want 0", bad_vs); else passed++;
    checks++; if ({prev_x, prev_y, spx, spy, sfs} !== {10'd14, 10'd8, 10'd0, 10'd0, 1'b1})
      $display("FAIL frame_wrap: got %0d,%0d->%0d,%0d fs=%b want 14,8->0,0 fs=1",
               prev_x, prev_y, spx, spy, sfs); else passed++;
  endtask

  // Starts on a frame_start sample of the small raster
  task automatic test_frame_period();
    int last = 0, nfs = 0, dbl = 0;
    int gap[3] = '{0, 0, 0};
    logic [9:0] max_x = '0, max_y = '0;
    logic prev_fs;
    for (int i = 1; i <= 3 * 270; i++) begin
      prev_fs = sfs;
      step();
      if (spx > max_x) max_x = spx;
      if (spy > max_y) max_y = spy;
      if (prev_fs && sfs) dbl++;
      if (sfs) begin
        if (nfs < 3) gap[nfs] = i - last;
        nfs++;
        last = i;
      end
    end
    checks++; if (nfs != 3) $display("FAIL fs_count: got %0d want 3", nfs); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (gap[k] != 270) $display("FAIL fs_gap%0d: got %0d want 270", k, gap[k]); else passed++;
    end
    checks++; if (dbl != 0) $display("FAIL fs_width: got %0d double pulses want 0", dbl); else passed++;
    checks++; if ((max_x > 10'd14) || (max_y > 10'd8))
      $display("FAIL range: got max %0d,%0d want <=14,8", max_x, max_y); else passed++;
  endtask

  task automatic test_midreset();
    int n = 0;
    while (!((spx == 10'd5) && (spy == 10'd3)) && n < 600) begin step(); n++; end
    checks++; if ({spx, spy} !== {10'd5, 10'd3}) $display("FAIL mid_reach: got %0d,%0d want 5,3", spx, spy); else passed++;
    #5 reset_n = 1'b0;
    #1;
    checks++; if (sst !== SRST) $display("FAIL mid_rst_small: got %h want %h", sst, SRST); else passed++;
    checks++; if (st !== RST) $display("FAIL mid_rst: got %h want %h", st, RST); else passed++;
    repeat (2) step();
    checks++; if (sst !== SRST) $display("FAIL mid_rst_hold: got %h want %h", sst, SRST); else passed++;
    @(negedge clk); reset_n = 1'b1;
    step();
    checks++; if (sst !== {10'd14, 10'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0})
      $display("FAIL mid_edge1: got %h want %h", sst, {10'd14, 10'd8, 5'b11010}); else passed++;
    step();
    checks++; if (sst !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL mid_edge2: got %h want %h", sst, {20'd0, 5'b11101}); else passed++;
    step();
    checks++; if (sst !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL mid_edge3: got %h want %h", sst, {20'd0, 5'b11110}); else passed++;
  endtask

  initial begin
    test_reset();
    test_release();
    test_hline();
    test_frame();
    test_frame_period();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
